// File: rtl/bus_priority_encoder.sv
// -----------------------------------------------------------------------------
// bus_priority_encoder
//   Captures an 8-bit request word and hands back the 3-bit index of every set
//   bit, lowest index first, one per valid/ready transfer. Bit k maps to index
//   k, so a 3-to-8 decoder driven from state_out rebuilds each captured bit.
//
// Ports
//   clk        in   1  clock, all state changes on the rising edge
//   rst_n      in   1  asynchronous active-low reset
//   bus_in     in   8  request word, sampled only when load is taken in IDLE
//   load       in   1  capture strobe, ignored while busy
//   state_out  out  3  index of lowest pending bit, 0 when out_valid is low
//   out_valid  out  1  state_out holds an index
//   out_ready  in   1  consumer takes the index when out_valid & out_ready
//   busy       out  1  block is emitting or finishing (load ignored)
//   done       out  1  one-cycle pulse after the word has been drained
//   bit_count  out  4  popcount of the last captured word
//   onehot     out  1  last captured word had exactly one bit set
// -----------------------------------------------------------------------------
module bus_priority_encoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] bus_in,
  input  logic       load,
  output logic [2:0] state_out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       done,
  output logic [3:0] bit_count,
  output logic       onehot
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EMIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0] state_q, state_d;
  logic [7:0] pending_q, pending_d;
  logic [3:0] bit_count_q, bit_count_d;
  logic [2:0] low_idx_s;
  logic [7:0] pending_cleared_s;

  // Number of set bits in an 8-bit word.
  function automatic logic [3:0] popcount8(input logic [7:0] w);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, w[i]};
    end
    return n;
  endfunction

  // Index of the lowest set bit; 0 for an all-zero word.
  function automatic logic [2:0] lowest_index(input logic [7:0] w);
    logic [2:0] idx;
    casez (w)
      8'b???????1: idx = 3'd0;
      8'b??????10: idx = 3'd1;
      8'b?????100: idx = 3'd2;
      8'b????1000: idx = 3'd3;
      8'b???10000: idx = 3'd4;
      8'b??100000: idx = 3'd5;
      8'b?1000000: idx = 3'd6;
      8'b10000000: idx = 3'd7;
      default:     idx = 3'd0;
    endcase
    return idx;
  endfunction

  assign low_idx_s = lowest_index(pending_q);
  // w & (w - 1) drops exactly the lowest set bit, i.e. the index being accepted.
  assign pending_cleared_s = pending_q & (pending_q - 8'd1);

  // Next-state, pending word and popcount update.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    bit_count_d = bit_count_q;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          pending_d   = bus_in;
          bit_count_d = popcount8(bus_in);
          if (bus_in != 8'h00) begin
            state_d = ST_EMIT;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          pending_d = pending_cleared_s;
          if (pending_cleared_s == 8'h00) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_EMIT;
          end
        end else begin
          state_d = ST_EMIT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        pending_d = 8'h00;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pending_q   <= 8'h00;
      bit_count_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      bit_count_q <= bit_count_d;
    end
  end

  // Outputs are decoded purely from registered state.
  always_comb begin
    out_valid = (state_q == ST_EMIT);
    busy      = (state_q == ST_EMIT) || (state_q == ST_DONE);
    done      = (state_q == ST_DONE);
    bit_count = bit_count_q;
    onehot    = (bit_count_q == 4'd1);
    if (state_q == ST_EMIT) begin
      state_out = low_idx_s;
    end else begin
      state_out = 3'b000;
    end
  end

endmodule
